// File: rtl/iob_cache_pkg.sv
// -----------------------------------------------------------------------------
// iob_cache_pkg
// Shared definitions for the cache write-through buffer.
//   - Default geometry (address, data and depth widths).
//   - Helper functions deriving NBYTES, DEPTH and the packed entry width from a
//     given configuration, so the buffer and its storage agree on the layout.
// Entry record layout (MSB..LSB): { addr, wdata, wstrb }.
// -----------------------------------------------------------------------------
package iob_cache_pkg;

  localparam int WTB_ADDR_W_DEF  = 30;
  localparam int WTB_DATA_W_DEF  = 32;
  localparam int WTB_DEPTH_W_DEF = 2;

  // Number of byte lanes in a data word.
  function automatic int wtb_nbytes(input int data_w);
    return data_w / 32'sd8;
  endfunction

  // Entry count for a given log2 depth.
  function automatic int wtb_depth(input int depth_w);
    return 32'sd1 <<< depth_w;
  endfunction

  // Width of one packed entry record { addr, wdata, wstrb }.
  function automatic int wtb_entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + wtb_nbytes(data_w);
  endfunction

endpackage

// File: rtl/iob_cache_wtb_mem.sv
// -----------------------------------------------------------------------------
// iob_cache_wtb_mem
// DEPTH-entry register file holding write-buffer entries.
//   clk_i             : clock
//   we_i              : write enable (already qualified by clock enable)
//   merge_i           : 0 = overwrite whole entry, 1 = byte-masked merge
//   wptr_i            : entry index written
//   waddr_i/wdata_i/wstrb_i : entry fields to write (wstrb_i is also the byte
//                       enable during a merge)
//   rptr_i            : entry index read (asynchronous)
//   raddr_o/rdata_o/rstrb_o : fields of the entry at rptr_i
// Storage is intentionally not reset; validity is tracked by the owner.
// -----------------------------------------------------------------------------
module iob_cache_wtb_mem
  import iob_cache_pkg::*;
#(
  parameter  int ADDR_W  = WTB_ADDR_W_DEF,
  parameter  int DATA_W  = WTB_DATA_W_DEF,
  parameter  int DEPTH_W = WTB_DEPTH_W_DEF,
  localparam int NBYTES  = wtb_nbytes(DATA_W)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic               merge_i,
  input  logic [DEPTH_W-1:0] wptr_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [NBYTES-1:0]  wstrb_i,
  input  logic [DEPTH_W-1:0] rptr_i,
  output logic [ADDR_W-1:0]  raddr_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic [NBYTES-1:0]  rstrb_o
);

  localparam int DEPTH    = wtb_depth(DEPTH_W);
  localparam int ENTRY_W  = wtb_entry_w(ADDR_W, DATA_W);
  localparam int STRB_LSB = 0;
  localparam int DATA_LSB = NBYTES;
  localparam int ADDR_LSB = NBYTES + DATA_W;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [ENTRY_W-1:0] rd_entry_s;

  // Entry write: full overwrite on allocation; on merge only strobed bytes are
  // replaced and their strobe bits set, which ORs the strobes together.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (merge_i) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wstrb_i[b]) begin
            mem_r[wptr_i][DATA_LSB + b*8 +: 8] <= wdata_i[b*8 +: 8];
            mem_r[wptr_i][STRB_LSB + b]        <= 1'b1;
          end
        end
      end else begin
        mem_r[wptr_i] <= {waddr_i, wdata_i, wstrb_i};
      end
    end
  end

  assign rd_entry_s = mem_r[rptr_i];
  assign raddr_o    = rd_entry_s[ADDR_LSB +: ADDR_W];
  assign rdata_o    = rd_entry_s[DATA_LSB +: DATA_W];
  assign rstrb_o    = rd_entry_s[STRB_LSB +: NBYTES];

endmodule

// File: rtl/iob_cache_write_buffer.sv
// -----------------------------------------------------------------------------
// iob_cache_write_buffer
// FIFO write buffer between the cache front-end and the memory back-end.
//   clk_i, arst_n_i, cke_i          : clock, async active-low reset, clock enable
//   push_valid_i/addr/wdata/wstrb   : front-end write request
//   push_ready_o                    : request accepted when high with valid
//   write_valid_o/addr/wdata/wstrb  : head entry presented to the back-end
//   write_ready_i                   : back-end consumes the head entry
//   empty_o, level_o                : occupancy (0..DEPTH)
// Optional feature (macro IOB_CACHE_WTB_MERGE_EN): a push whose address matches
// the tail entry is merged into it when at least two entries are held, so the
// head entry the back-end may be consuming is never modified.
// -----------------------------------------------------------------------------
module iob_cache_write_buffer
  import iob_cache_pkg::*;
#(
  parameter  int ADDR_W  = WTB_ADDR_W_DEF,
  parameter  int DATA_W  = WTB_DATA_W_DEF,
  parameter  int DEPTH_W = WTB_DEPTH_W_DEF,
  localparam int NBYTES  = wtb_nbytes(DATA_W)
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               cke_i,
  input  logic               push_valid_i,
  input  logic [ADDR_W-1:0]  push_addr_i,
  input  logic [DATA_W-1:0]  push_wdata_i,
  input  logic [NBYTES-1:0]  push_wstrb_i,
  output logic               push_ready_o,
  output logic               write_valid_o,
  output logic [ADDR_W-1:0]  write_addr_o,
  output logic [DATA_W-1:0]  write_wdata_o,
  output logic [NBYTES-1:0]  write_wstrb_o,
  input  logic               write_ready_i,
  output logic               empty_o,
  output logic [DEPTH_W:0]   level_o
);

  // Level is one bit wider than the pointers so DEPTH itself is representable.
  localparam logic [DEPTH_W:0]   LEVEL_ZERO = {(DEPTH_W+1){1'b0}};
  localparam logic [DEPTH_W:0]   LEVEL_ONE  = (DEPTH_W+1)'(1'b1);
  localparam logic [DEPTH_W:0]   LEVEL_FULL = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W-1:0] PTR_ONE    = DEPTH_W'(1'b1);

  logic [DEPTH_W-1:0] wr_ptr_r;
  logic [DEPTH_W-1:0] rd_ptr_r;
  logic [DEPTH_W:0]   level_r;

  logic               full_s;
  logic               merge_s;
  logic               push_s;
  logic               alloc_s;
  logic               pop_s;
  logic               mem_we_s;
  logic [DEPTH_W-1:0] mem_wptr_s;

`ifdef IOB_CACHE_WTB_MERGE_EN
  // Copy of the most recently allocated address, i.e. the tail entry address;
  // avoids a second read port on the register file.
  logic [ADDR_W-1:0]  tail_addr_r;

  // Tail address tracking; a merge keeps the same address so only allocations update it.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tail_addr_r <= {ADDR_W{1'b0}};
    end else if (cke_i && alloc_s) begin
      tail_addr_r <= push_addr_i;
    end
  end

  // Merge eligibility: two or more entries held, so the tail is never the head.
  always_comb begin
    merge_s = 1'b0;
    if ((level_r > LEVEL_ONE) && (push_addr_i == tail_addr_r)) begin
      merge_s = 1'b1;
    end else begin
      merge_s = 1'b0;
    end
  end
`else
  assign merge_s = 1'b0;
`endif

  assign full_s        = (level_r == LEVEL_FULL);
  // Full refuses new allocations even if the head pops this same cycle.
  assign push_ready_o  = !full_s || merge_s;
  assign push_s        = push_valid_i && push_ready_o && cke_i;
  assign alloc_s       = push_s && !merge_s;
  assign pop_s         = write_valid_o && write_ready_i && cke_i;

  assign empty_o       = (level_r == LEVEL_ZERO);
  assign write_valid_o = !empty_o;
  assign level_o       = level_r;

  // Storage write port: allocations go to wr_ptr, merges to the tail entry behind it.
  always_comb begin
    mem_we_s   = alloc_s || (push_s && merge_s);
    mem_wptr_s = wr_ptr_r;
    if (merge_s) begin
      mem_wptr_s = wr_ptr_r - PTR_ONE;
    end else begin
      mem_wptr_s = wr_ptr_r;
    end
  end

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_r <= {DEPTH_W{1'b0}};
      rd_ptr_r <= {DEPTH_W{1'b0}};
      level_r  <= LEVEL_ZERO;
    end else if (cke_i) begin
      if (alloc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({alloc_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  iob_cache_wtb_mem #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we_s),
    .merge_i (merge_s),
    .wptr_i  (mem_wptr_s),
    .waddr_i (push_addr_i),
    .wdata_i (push_wdata_i),
    .wstrb_i (push_wstrb_i),
    .rptr_i  (rd_ptr_r),
    .raddr_o (write_addr_o),
    .rdata_o (write_wdata_o),
    .rstrb_o (write_wstrb_o)
  );

endmodule

// File: doc/iob_cache_write_buffer.md
IOB_CACHE_WRITE_BUFFER -- requirements
Module: iob_cache_write_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word address width (byte address bits FE_ADDR_W-1:2).
REQ-002 SHALL have parameter DATA_W, default 32, data word width; NBYTES = DATA_W/8.
REQ-003 SHALL have parameter DEPTH_W, default 2, log2 of entry count; DEPTH = 2**DEPTH_W, DEPTH_W >= 1.
REQ-004 SHALL have the following ports, in this order:
- clk_i in 1: clock; one clock domain.
- arst_n_i in 1: reset, asynchronous, active-low.
- cke_i in 1: clock enable; all state holds when 0.
- push_valid_i in 1: front-end write request.
- push_addr_i in ADDR_W: word address.
- push_wdata_i in DATA_W: write data.
- push_wstrb_i in NBYTES: byte strobes.
- push_ready_o out 1: push accepted this cycle when high with push_valid_i.
- write_valid_o out 1: head entry valid, to back-end write_valid_i.
- write_addr_o out ADDR_W: head address.
- write_wdata_o out DATA_W: head data.
- write_wstrb_o out NBYTES: head strobes.
- write_ready_i in 1: back-end accepts head, from back-end write_ready_o.
- empty_o out 1: no entries held.
- level_o out DEPTH_W+1: entries held, 0..DEPTH.

Function
REQ-005 SHALL store entries first-in first-out; push = push_valid_i & push_ready_o & cke_i; pop = write_valid_o & write_ready_i & cke_i.
REQ-006 SHALL drive push_ready_o = (level_o != DEPTH), independent of write_ready_i; full buffer refuses push even when popping (merge excepted, REQ-014).
REQ-007 SHALL drive write_valid_o = !empty_o; write_addr_o/wdata_o/wstrb_o = head entry, combinationally from storage.
REQ-008 SHALL make a pushed entry visible on write_* the cycle after the push edge (latency 1) when the buffer was empty.
REQ-009 SHALL keep write_* stable while write_valid_o=1 and write_ready_i=0.
REQ-010 SHALL on simultaneous push and pop update level_o unchanged, advance both pointers, wrap pointers modulo DEPTH.
REQ-011 SHALL ignore write_ready_i when empty and push_valid_i when not ready; no state change, no overflow or underflow.
REQ-012 SHALL accept push_wstrb_i = 0 as a normal entry, passed through unchanged.
REQ-013 SHALL drive empty_o = (level_o == 0); level_o computed without overflow at DEPTH.

Reset
REQ-015 SHALL on arst_n_i low asynchronously clear pointers and level: level_o=0, empty_o=1, write_valid_o=0, push_ready_o=1; storage contents need not be reset.
REQ-016 SHALL discard entries held when reset asserts mid-operation; first cycle after deassertion behaves as empty.

Configuration
REQ-014 SHALL with macro IOB_CACHE_WTB_MERGE_EN defined merge a push into the tail entry when level_o >= 2 and push_addr_i equals tail address: tail wstrb |= push_wstrb_i, tail data bytes with push strobe set replaced; level unchanged; push_ready_o high for a merge-eligible push even when full. The head entry is never merged into. Without the macro every push allocates a new entry, no address compare logic exists.

Structure
REQ-017 SHALL take DEPTH, NBYTES and the entry record (addr, wdata, wstrb) widths from shared package iob_cache_pkg.
REQ-018 SHALL contain one sub-module iob_cache_wtb_mem: DEPTH-entry register file, one write port (with per-byte enable for merge), one asynchronous read port; pointer/level control stays in the top module.

Verification
REQ-019 SHALL cover: reset, push addr 0x10 data 0xDEADBEEF wstrb 0xF, write_ready_i=0 -> next cycle write_valid_o=1, write_addr_o=0x10, write_wdata_o=0xDEADBEEF, level_o=1, values stable until ready.
REQ-020 SHALL cover: 4 pushes (addr 1,2,3,4), write_ready_i=0 -> push_ready_o=0, level_o=4; 5th push (addr 5) refused; then ready=1 -> pops in order 1,2,3,4, empty_o=1.
REQ-021 SHALL cover: full buffer, push_valid_i=1 and write_ready_i=1 same cycle -> pop occurs, push refused, level_o=3.
REQ-022 SHALL cover: level_o=2, push and pop same cycle -> level_o stays 2, order preserved across pointer wrap after 10 such cycles.
REQ-023 SHALL cover: with IOB_CACHE_WTB_MERGE_EN, entries addr 7 and addr 9 (data 0x11111111, wstrb 0xF), push addr 9 data 0xAABBCCDD wstrb 0x3 -> level_o=2, second pop shows 0x1111CCDD wstrb 0xF; without the macro level_o=3.
REQ-024 SHALL cover: arst_n_i pulsed low with level_o=3 -> immediately level_o=0, write_valid_o=0, push_ready_o=1.
